cram_loader: RTL and testbench



---
 rtl/cram_pkg.sv | 35 +++
 rtl/cram_loader_crc16.sv | 21 ++
 rtl/cram_loader.sv | 236 +++++++++++++++++++++++
 tb/tb_cram_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cram_pkg.sv
// Shared types, constants and geometry helpers for the CRAM bitstream loader.
package cram_pkg;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        CRC     = 3'd3,
        SETTLE  = 3'd4,
        RELEASE = 3'd5
    } state_e;

    // Select width for one routing mux: 2*bus_width+2 candidate sources.
    function automatic int unsigned calc_sel_bits(input int unsigned bus_width);
        return $clog2(2 * bus_width + 2);
    endfunction

    // CRAM bits held by one fpgacell.
    function automatic int unsigned calc_cfg_bits(input int unsigned bus_width,
                                                  input int unsigned le_inputs,
                                                  input int unsigned le_outputs,
                                                  input int unsigned le_lut_size);
        return bus_width * 8
             + 4 * (le_inputs + le_outputs) * calc_sel_bits(bus_width)
             + le_lut_size + 1;
    endfunction

    function automatic int unsigned calc_nbytes(input int unsigned total_bits);
        return (total_bits + 7) / 8;
    endfunction

endpackage

// File: rtl/cram_loader_crc16.sv
// Combinational CRC-16-CCITT update over one byte, MSB first.
module crc16_byte
    import cram_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out_c
);

    always_comb begin
        crc_out_c = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (crc_out_c[15] ^ data_in[3'(7 - i)]) begin
                crc_out_c = {crc_out_c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_out_c = {crc_out_c[14:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/cram_loader.sv
// Byte-stream to serial CRAM chain loader; holds the fabric in reset while loading.
// Define CRAM_CRC_EN to require a trailing CRC-16 over the payload before release.
module cram_loader
    import cram_pkg::*;
#(
    parameter int unsigned BUS_WIDTH   = 4,
    parameter int unsigned LE_INPUTS   = 4,
    parameter int unsigned LE_OUTPUTS  = 1,
    parameter int unsigned LE_LUT_SIZE = 16,
    parameter int unsigned NUM_CELLS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       config_data_in,
    output logic       config_en,
    input  logic       config_data_out,
    output logic       fab_nrst,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned CFG_BITS   = calc_cfg_bits(BUS_WIDTH, LE_INPUTS, LE_OUTPUTS, LE_LUT_SIZE);
    localparam int unsigned TOTAL_BITS = NUM_CELLS * CFG_BITS;
    localparam int unsigned NBYTES     = calc_nbytes(TOTAL_BITS);
    localparam int unsigned CNT_W      = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         sreg_q, sreg_d;
    logic               fab_nrst_q, fab_nrst_d;
    logic               in_ready_q, in_ready_d;
    logic               config_en_q, config_en_d;
    logic               config_data_in_q, config_data_in_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               hs_c;
    logic               unused_c;

    // The chain tail is not consumed by the loader.
    assign unused_c = config_data_out;

    assign hs_c = in_valid && in_ready_q;

`ifdef CRAM_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic [15:0] crc_next_c;
    logic [7:0]  crc_hi_q, crc_hi_d;
    logic        err_q, err_d;
    logic        payload_hs_c;
    logic        crc_match_c;

    crc16_byte u_crc (
        .crc_in    (crc_q),
        .data_in   (in_data),
        .crc_out_c (crc_next_c)
    );

    assign payload_hs_c = hs_c && ((state_q == LOAD) || (state_q == SHIFT));
    assign crc_match_c  = ({crc_hi_q, in_data} == crc_q);

    // Running payload CRC, captured high byte and sticky error.
    always_comb begin
        crc_d    = crc_q;
        crc_hi_d = crc_hi_q;
        err_d    = err_q;
        if ((state_q == IDLE) && start) begin
            crc_d = CRC_INIT;
            err_d = 1'b0;
        end else if (payload_hs_c) begin
            crc_d = crc_next_c;
        end else if ((state_q == CRC) && hs_c) begin
            if (bit_cnt_q == 3'd0) begin
                crc_hi_d = in_data;
            end else if (!crc_match_c) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q    <= 16'h0000;
            crc_hi_q <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            crc_q    <= crc_d;
            crc_hi_q <= crc_hi_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            byte_cnt_q       <= '0;
            bit_cnt_q        <= 3'd0;
            sreg_q           <= 8'h00;
            fab_nrst_q       <= 1'b0;
            in_ready_q       <= 1'b0;
            config_en_q      <= 1'b0;
            config_data_in_q <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            byte_cnt_q       <= byte_cnt_d;
            bit_cnt_q        <= bit_cnt_d;
            sreg_q           <= sreg_d;
            fab_nrst_q       <= fab_nrst_d;
            in_ready_q       <= in_ready_d;
            config_en_q      <= config_en_d;
            config_data_in_q <= config_data_in_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    // Next state; byte_cnt indexes the byte currently in (or next loaded into) sreg.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sreg_d     = sreg_q;
        fab_nrst_d = fab_nrst_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    byte_cnt_d = '0;
                    fab_nrst_d = 1'b0;
                end
            end
            LOAD: begin
                if (hs_c) begin
                    sreg_d    = in_data;
                    bit_cnt_d = 3'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q != 3'd7) begin
                    sreg_d    = {sreg_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end else if (byte_cnt_q < LAST_BYTE) begin
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (hs_c) begin
                        sreg_d    = in_data;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    bit_cnt_d = 3'd0;
`ifdef CRAM_CRC_EN
                    state_d   = CRC;
`else
                    state_d   = SETTLE;
`endif
                end
            end
`ifdef CRAM_CRC_EN
            CRC: begin
                if (hs_c) begin
                    if (bit_cnt_q == 3'd0) begin
                        bit_cnt_d = 3'd1;
                    end else begin
                        bit_cnt_d = 3'd0;
                        state_d   = crc_match_c ? SETTLE : IDLE;
                    end
                end
            end
`endif
            SETTLE: begin
                if (bit_cnt_q == 3'd1) begin
                    bit_cnt_d  = 3'd0;
                    state_d    = RELEASE;
                    fab_nrst_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from next-state values so the registers line up with state_q.
    always_comb begin
        in_ready_d       = 1'b0;
        config_en_d      = 1'b0;
        config_data_in_d = 1'b0;
        busy_d           = (state_d != IDLE);
        done_d           = (state_d == RELEASE);
        unique case (state_d)
            LOAD: begin
                in_ready_d = 1'b1;
            end
            SHIFT: begin
                config_en_d      = 1'b1;
                config_data_in_d = sreg_d[7];
                in_ready_d       = (bit_cnt_d == 3'd7) && (byte_cnt_d < LAST_BYTE);
            end
            CRC: begin
                in_ready_d = 1'b1;
            end
            default: begin
                in_ready_d = 1'b0;
            end
        endcase
    end

    assign in_ready       = in_ready_q;
    assign config_en      = config_en_q;
    assign config_data_in = config_data_in_q;
    assign fab_nrst       = fab_nrst_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_cram_loader.sv
// Directed self-checking bench for cram_loader at default geometry (129-bit cell, 17 bytes).
module tb_cram_loader;

    localparam int unsigned NB  = 17;
    localparam int unsigned TOT = 129;
`ifdef CRAM_CRC_EN
    localparam int unsigned NSEND    = 19;
    localparam int unsigned DONE_LAT = 5;
`else
    localparam int unsigned NSEND    = 17;
    localparam int unsigned DONE_LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       config_data_in;
    logic       config_en;
    logic       config_data_out;
    logic       fab_nrst;
    logic       busy;
    logic       done;
    logic       err;

    logic [TOT-1:0] chain = '0;
    logic           mon_clr = 1'b0;
    logic           en_prev = 1'b0;
    int             cyc = 0;
    int             en_cnt = 0;
    int             en_runs = 0;
    int             first_en = 0;
    int             last_en = 0;
    int             done_cyc = 0;
    int             done_cnt = 0;

    logic [7:0]     mem [0:18];
    logic [TOT-1:0] exp_a, exp_b, exp_c;
    int             checks = 0;
    int             errors = 0;

    always #5 clk = ~clk;

    assign config_data_out = chain[TOT-1];

    cram_loader dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .config_data_in  (config_data_in),
        .config_en       (config_en),
        .config_data_out (config_data_out),
        .fab_nrst        (fab_nrst),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    // Behavioural CRAM chain plus activity monitor.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        en_prev <= config_en;
        if (config_en) chain <= {chain[TOT-2:0], config_data_in};
        if (mon_clr) begin
            en_cnt   <= 0;
            en_runs  <= 0;
            first_en <= 0;
            last_en  <= 0;
            done_cyc <= 0;
            done_cnt <= 0;
        end else begin
            if (config_en) begin
                en_cnt  <= en_cnt + 1;
                last_en <= cyc;
                if (!en_prev) en_runs <= en_runs + 1;
                if (en_cnt == 0) first_en <= cyc;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef CRAM_CRC_EN
    function automatic logic [15:0] crc_ref(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {mem[i], 8'h00};
            for (int b = 0; b < 8; b++) begin
                c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction
`endif

    // Fill mem with a pattern; expected chain = last TOT bits of the stream.
    task automatic build(input int kind, output logic [TOT-1:0] exp);
        logic [135:0] s;
        s = '0;
        for (int i = 0; i < int'(NB); i++) begin
            case (kind)
                0:       mem[i] = 8'(32'hA5 ^ (i * 13));
                1:       mem[i] = 8'(i * 17) ^ 8'h3C;
                default: mem[i] = 8'(255 - i * 7);
            endcase
            s = {s[127:0], mem[i]};
        end
        exp = s[TOT-1:0];
`ifdef CRAM_CRC_EN
        begin
            logic [15:0] c;
            c = crc_ref(int'(NB));
            mem[17] = c[15:8];
            mem[18] = c[7:0];
        end
`endif
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Stream nbytes from mem; optional stall before byte stall_idx and a start pulse at busy_idx.
    task automatic send(input int nbytes, input int stall_idx, input int stall_len, input int busy_idx);
        int   idx;
        int   n;
        int   stall_left;
        bit   pulsed;
        logic hs;
        idx = 0;
        n = 0;
        stall_left = stall_len;
        pulsed = 1'b0;
        while (idx < nbytes && n < 2000) begin
            in_data  = mem[idx];
            in_valid = !(idx == stall_idx && stall_left > 0);
            start    = (idx == busy_idx) && !pulsed;
            if (start) pulsed = 1'b1;
            @(negedge clk);
            hs = in_valid && in_ready;
            if (!in_valid && in_ready) stall_left--;
            tick();
            n++;
            if (hs) idx++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("send_count", 192'(idx), 192'(nbytes));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk("idle_timeout", 192'(busy), 192'(0));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();

        chk("rst_in_ready", 192'(in_ready), 192'(0));
        chk("rst_config_en", 192'(config_en), 192'(0));
        chk("rst_config_data_in", 192'(config_data_in), 192'(0));
        chk("rst_fab_nrst", 192'(fab_nrst), 192'(0));
        chk("rst_busy", 192'(busy), 192'(0));
        chk("rst_done", 192'(done), 192'(0));
        chk("rst_err", 192'(err), 192'(0));

        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        tick();
        chk("idle_in_ready", 192'(in_ready), 192'(0));
        chk("idle_busy", 192'(busy), 192'(0));
        chk("idle_config_en", 192'(config_en), 192'(0));
        in_valid = 1'b0;

        // Back-to-back load
        build(0, exp_a);
        clr_mon();
        do_start();
        chk("a_busy", 192'(busy), 192'(1));
        chk("a_in_ready", 192'(in_ready), 192'(1));
        chk("a_nrst_low", 192'(fab_nrst), 192'(0));
        send(int'(NSEND), -1, 0, -1);
        wait_idle();
        chk("a_en_cnt", 192'(en_cnt), 192'(136));
        chk("a_en_runs", 192'(en_runs), 192'(1));
        chk("a_en_span", 192'(last_en - first_en + 1), 192'(136));
        chk("a_done_lat", 192'(done_cyc - last_en), 192'(DONE_LAT));
        chk("a_done_cnt", 192'(done_cnt), 192'(1));
        chk("a_fab_nrst", 192'(fab_nrst), 192'(1));
        chk("a_err", 192'(err), 192'(0));
        chk("a_chain", 192'(chain), 192'(exp_a));

        // Source stalls for 5 cycles after byte 4
        clr_mon();
        do_start();
        send(int'(NSEND), 4, 5, -1);
        wait_idle();
        chk("s_en_cnt", 192'(en_cnt), 192'(136));
        chk("s_en_runs", 192'(en_runs), 192'(2));
        chk("s_en_span", 192'(last_en - first_en + 1), 192'(141));
        chk("s_done_lat", 192'(done_cyc - last_en), 192'(DONE_LAT));
        chk("s_chain", 192'(chain), 192'(exp_a));
        chk("s_fab_nrst", 192'(fab_nrst), 192'(1));

        // Reset after byte 9, then a fresh full load
        build(1, exp_b);
        clr_mon();
        do_start();
        chk("r_nrst_low", 192'(fab_nrst), 192'(0));
        send(9, -1, 0, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_busy", 192'(busy), 192'(0));
        chk("r_config_en", 192'(config_en), 192'(0));
        chk("r_fab_nrst", 192'(fab_nrst), 192'(0));
        chk("r_in_ready", 192'(in_ready), 192'(0));
        clr_mon();
        do_start();
        send(int'(NSEND), -1, 0, -1);
        wait_idle();
        chk("r2_en_cnt", 192'(en_cnt), 192'(136));
        chk("r2_done_cnt", 192'(done_cnt), 192'(1));
        chk("r2_fab_nrst", 192'(fab_nrst), 192'(1));
        chk("r2_chain", 192'(chain), 192'(exp_b));

        // start pulsed during SHIFT is ignored
        build(2, exp_c);
        clr_mon();
        do_start();
        send(int'(NSEND), -1, 0, 6);
        wait_idle();
        chk("b_en_cnt", 192'(en_cnt), 192'(136));
        chk("b_en_runs", 192'(en_runs), 192'(1));
        chk("b_en_span", 192'(last_en - first_en + 1), 192'(136));
        chk("b_done_lat", 192'(done_cyc - last_en), 192'(DONE_LAT));
        chk("b_done_cnt", 192'(done_cnt), 192'(1));
        chk("b_chain", 192'(chain), 192'(exp_c));

`ifdef CRAM_CRC_EN
        // Corrupted low CRC byte
        build(0, exp_a);
        mem[18] = mem[18] ^ 8'h01;
        clr_mon();
        do_start();
        send(int'(NSEND), -1, 0, -1);
        wait_idle();
        chk("c_err", 192'(err), 192'(1));
        chk("c_fab_nrst", 192'(fab_nrst), 192'(0));
        chk("c_done_cnt", 192'(done_cnt), 192'(0));
        chk("c_en_cnt", 192'(en_cnt), 192'(136));
        do_start();
        chk("c_err_clear", 192'(err), 192'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
